// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-step MULT/MULTU/DIV/DIVU engine with architectural HI/LO
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DZ} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_sx, r_sy, r_busy, r_done, r_dz;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic [WIDTH-1:0]   w_xmag, w_ymag, w_q, w_r;
    logic [WIDTH:0]     w_sum, w_up, w_diff;
    logic [2*WIDTH-1:0] w_step, w_prod;
    assign w_xmag = (op[0] && X[WIDTH-1]) ? -X : X;
    assign w_ymag = (op[0] && Y[WIDTH-1]) ? -Y : Y;
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_up   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff = w_up - {1'b0, r_b};
    // divide: shift-subtract restoring step; multiply: conditional add then shift right
    assign w_step = r_div ? (w_diff[WIDTH] ? {w_up[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                           : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                          : {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod = (r_sx ^ r_sy) ? -r_acc : r_acc;
    assign w_q    = (r_sx ^ r_sy) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r    = r_sx ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign HI       = r_hi;
    assign LO       = r_lo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_acc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (!r_busy && mthi) r_hi <= X;
            if (!r_busy && mtlo) r_lo <= X;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    // busy still high here means this is the done cycle, so start is ignored
                    if (start && !r_busy) begin
                        r_busy  <= 1'b1;
                        r_dz    <= 1'b0;
                        r_div   <= op[1];
                        r_sx    <= op[0] & X[WIDTH-1];
                        r_sy    <= op[0] & Y[WIDTH-1];
                        r_b     <= op[1] ? w_ymag : w_xmag;
                        r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_xmag : w_ymag)};
                        r_cnt   <= '0;
                        r_state <= (op[1] && Y == '0) ? S_DZ : S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= r_div ? w_q : w_prod[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_DZ: begin
                    r_done  <= 1'b1;
                    r_dz    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks against an arithmetic reference model
module tb_muldiv_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] X = '0, Y = '0;
    logic        busy, done, div_zero;
    logic [31:0] HI, LO;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(X), .Y(Y),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] hi, inout logic [31:0] lo, output logic dz);
        longint sx, sy;
        logic [63:0] p;
        dz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = {32'b0, x} * {32'b0, y}; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = 64'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
            2'd2: if (y == 0) dz = 1'b1; else begin lo = x / y; hi = x % y; end
            default: if (y == 0) dz = 1'b1; else begin lo = 32'(sx / sy); hi = 32'(sx % sy); end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic wh, output int cyc, output int bc, output logic stable,
                          output logic dz0, output logic dzd, output logic b_after, output logic d_after);
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; op = o; X = x; Y = y; mthi = wh;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        h0 = HI; l0 = LO; stable = 1'b1; dz0 = div_zero; cyc = 0; bc = 0;
        while (!done && cyc < 100) begin
            bc += int'(busy);
            @(negedge clk);
            cyc++;
            if (!done && (HI !== h0 || LO !== l0)) stable = 1'b0;
        end
        bc += int'(busy);
        dzd = div_zero;
        @(negedge clk);
        b_after = busy; d_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, div_zero} !== 3'b000 || HI !== 0 || LO !== 0) begin
            n_fail++;
            $display("FAIL reset: busy/done/dz=%b HI=%h LO=%h required 000/0/0", {busy, done, div_zero}, HI, LO);
        end
        rst_n = 1'b1;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_timing;
        int cyc, bc;
        logic st, dz0, dzd, ba, da, dz;
        model(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, m_hi, m_lo, dz);
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, bc, st, dz0, dzd, ba, da);
        n_chk++;
        if (cyc != 33) begin n_fail++; $display("FAIL timing_done: %0d cycles after accept, required 33", cyc); end
        n_chk++;
        if (bc != 34) begin n_fail++; $display("FAIL timing_busy: busy %0d cycles, required 34", bc); end
        n_chk++;
        if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            n_fail++; $display("FAIL multu_max: HI=%h LO=%h required FFFFFFFE/00000001", HI, LO);
        end
        n_chk++;
        if (ba !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL after_done: busy=%b done=%b required 0/0", ba, da); end
    endtask

    task automatic test_arith;
        logic [1:0]  vo[$];
        logic [31:0] vx[$], vy[$];
        int cyc, bc;
        logic st, dz0, dzd, ba, da, dz;
        vo = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
        vx = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h80000000, 32'd7, 32'd0};
        vy = '{32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'h12345678};
        for (int i = 0; i < 40; i++) begin
            vo.push_back(2'($urandom_range(0, 3)));
            vx.push_back($urandom);
            vy.push_back(($urandom_range(0, 15) == 0) ? 32'd0 :
                         ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
        end
        for (int i = 0; i < vo.size(); i++) begin
            model(vo[i], vx[i], vy[i], m_hi, m_lo, dz);
            run_op(vo[i], vx[i], vy[i], 1'b0, cyc, bc, st, dz0, dzd, ba, da);
            n_chk++;
            if (cyc != (dz ? 1 : 33)) begin n_fail++; $display("FAIL latency[%0d]: %0d required %0d", i, cyc, dz ? 1 : 33); end
            n_chk++;
            if (HI !== m_hi || LO !== m_lo) begin
                n_fail++;
                $display("FAIL result[%0d] op=%0d X=%h Y=%h: HI=%h LO=%h required %h/%h", i, vo[i], vx[i], vy[i], HI, LO, m_hi, m_lo);
            end
            n_chk++;
            if (dzd !== dz || dz0 !== 1'b0) begin n_fail++; $display("FAIL div_zero[%0d]: at done %b after accept %b required %b/0", i, dzd, dz0, dz); end
            n_chk++;
            if (st !== 1'b1) begin n_fail++; $display("FAIL hilo_stable[%0d]: HI/LO changed before done", i); end
        end
    endtask

    task automatic test_dz;
        int cyc, bc;
        logic st, dz0, dzd, ba, da;
        @(negedge clk); mthi = 1'b1; X = 32'h11;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; X = 32'h22;
        @(negedge clk); mtlo = 1'b0;
        n_chk++;
        if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL preload: HI=%h LO=%h required 11/22", HI, LO); end
        run_op(2'd2, 32'd5, 32'd0, 1'b0, cyc, bc, st, dz0, dzd, ba, da);
        n_chk++;
        if (cyc != 1 || dzd !== 1'b1 || bc != 2) begin
            n_fail++; $display("FAIL dz_timing: cyc=%0d dz=%b busy=%0d required 1/1/2", cyc, dzd, bc);
        end
        n_chk++;
        if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL dz_hold: HI=%h LO=%h required 11/22", HI, LO); end
        @(negedge clk); mthi = 1'b1; X = 32'h33;
        @(negedge clk); mthi = 1'b0;
        n_chk++;
        if (HI !== 32'h33 || div_zero !== 1'b1) begin n_fail++; $display("FAIL mthi_dz: HI=%h dz=%b required 33/1", HI, div_zero); end
        run_op(2'd2, 32'h55, 32'd0, 1'b1, cyc, bc, st, dz0, dzd, ba, da);
        n_chk++;
        if (HI !== 32'h55 || LO !== 32'h22) begin n_fail++; $display("FAIL mthi_with_start: HI=%h LO=%h required 55/22", HI, LO); end
        run_op(2'd0, 32'd6, 32'd7, 1'b1, cyc, bc, st, dz0, dzd, ba, da);
        n_chk++;
        if (HI !== 0 || LO !== 42 || dz0 !== 1'b0) begin
            n_fail++; $display("FAIL commit_over_mthi: HI=%h LO=%h dz=%b required 0/2a/0", HI, LO, dz0);
        end
        m_hi = 0; m_lo = 42;
    endtask

    task automatic test_ignore;
        int cyc;
        logic dz;
        model(2'd1, 32'hFFFFFFFD, 32'd7, m_hi, m_lo, dz);
        @(negedge clk); start = 1'b1; op = 2'd1; X = 32'hFFFFFFFD; Y = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'd2; X = 32'hDEADBEEF; Y = 32'd0; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk); start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        n_chk++;
        if (cyc != 27 || HI !== m_hi || LO !== m_lo || div_zero !== 1'b0) begin
            n_fail++; $display("FAIL ignore_busy: cyc=%0d HI=%h LO=%h dz=%b required 27/%h/%h/0", cyc, HI, LO, div_zero, m_hi, m_lo);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || HI !== m_hi) begin n_fail++; $display("FAIL no_queue: busy=%b HI=%h required 0/%h", busy, HI, m_hi); end
    endtask

    task automatic test_mid_reset;
        int cyc, bc, seen;
        logic st, dz0, dzd, ba, da;
        @(negedge clk); start = 1'b1; op = 2'd0; X = 32'h1234; Y = 32'h5678;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (HI !== 0 || LO !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: HI=%h LO=%h busy=%b done=%b required 0/0/0/0", HI, LO, busy, done);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); seen += int'(done | busy); end
        n_chk++;
        if (seen != 0) begin n_fail++; $display("FAIL abort: done/busy seen %0d cycles after reset, required 0", seen); end
        run_op(2'd0, 32'd3, 32'd4, 1'b0, cyc, bc, st, dz0, dzd, ba, da);
        n_chk++;
        if (HI !== 0 || LO !== 12 || cyc != 33) begin
            n_fail++; $display("FAIL post_reset_op: HI=%h LO=%h cyc=%0d required 0/c/33", HI, LO, cyc);
        end
    endtask

    initial begin
        test_reset;
        test_timing;
        test_arith;
        test_dz;
        test_ignore;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
